// File: rtl/reg_bus_arbiter_pkg.sv
// reg_bus_arbiter_pkg: shared state encoding, owner codes and burst counter width
package reg_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, DONE} state_e;
  localparam logic OWNER_FW  = 1'b0;
  localparam logic OWNER_ETH = 1'b1;
  localparam int   BURST_W   = 8;
endpackage

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: serialises FireWire and Ethernet host quadlet accesses onto the register-file bus,
// round-robin with an optional bounded lock for short bursts
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        fw_req,
  input  logic        fw_wr,
  input  logic        fw_lock,
  input  logic [15:0] fw_addr,
  input  logic [31:0] fw_wdata,
  output logic        fw_ack,
  output logic [31:0] fw_rdata,
  input  logic        eth_req,
  input  logic        eth_wr,
  input  logic        eth_lock,
  input  logic [15:0] eth_addr,
  input  logic [31:0] eth_wdata,
  output logic        eth_ack,
  output logic [31:0] eth_rdata,
  output logic [15:0] reg_raddr,
  output logic [15:0] reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        reg_wen,
  input  logic [31:0] reg_rdata,
  output logic        owner,
  output logic        busy
);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [2:0]         CNT_LAST  = 3'(RD_LATENCY - 1);
  state_e             state_q, state_d;
  logic               owner_q, owner_d, lock_q, lock_d, wr_q, wr_d, gnt;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [15:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d, fw_rdata_q, fw_rdata_d, eth_rdata_q, eth_rdata_d;
  // lock_q is the last owner's lock as seen at its DONE, so it only ever favours that owner
  function automatic logic grant(input logic fw, input logic eth, input logic own,
                                 input logic lk, input logic [BURST_W-1:0] cnt);
    return (fw && eth) ? ((lk && cnt < BURST_MAX) ? own : ~own) : eth;
  endfunction
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_ETH;
      lock_q      <= 1'b0;
      wr_q        <= 1'b0;
      burst_q     <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fw_rdata_q  <= '0;
      eth_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lock_q      <= lock_d;
      wr_q        <= wr_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fw_rdata_q  <= fw_rdata_d;
      eth_rdata_q <= eth_rdata_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lock_d      = lock_q;
    wr_d        = wr_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fw_rdata_d  = fw_rdata_q;
    eth_rdata_d = eth_rdata_q;
    gnt         = grant(fw_req, eth_req, owner_q, lock_q, burst_q);
    case (state_q)
      IDLE: if (fw_req || eth_req) begin
        state_d = ACCESS;
        owner_d = gnt;
        wr_d    = gnt ? eth_wr : fw_wr;
        addr_d  = gnt ? eth_addr : fw_addr;
        wdata_d = gnt ? eth_wdata : fw_wdata;
        burst_d = (gnt == owner_q && lock_q) ? ((burst_q < BURST_MAX) ? burst_q + BURST_W'(1) : burst_q) : '0;
      end
      ACCESS: begin
        state_d = wr_q ? DONE : RWAIT;
        cnt_d   = '0;
      end
      RWAIT: if (cnt_q == CNT_LAST) begin
        state_d     = DONE;
        fw_rdata_d  = owner_q ? fw_rdata_q : reg_rdata;
        eth_rdata_d = owner_q ? reg_rdata : eth_rdata_q;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
      DONE: begin
        state_d = IDLE;
        lock_d  = owner_q ? eth_lock : fw_lock;
        burst_d = (owner_q ? eth_lock : fw_lock) ? burst_q : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign reg_raddr = addr_q;
  assign reg_waddr = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wen   = (state_q == ACCESS) && wr_q;
  assign fw_ack    = (state_q == DONE) && (owner_q == OWNER_FW);
  assign eth_ack   = (state_q == DONE) && (owner_q == OWNER_ETH);
  assign fw_rdata  = fw_rdata_q;
  assign eth_rdata = eth_rdata_q;
  assign owner     = owner_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed and randomized checks of reg_bus_arbiter against a transaction-level model
module tb_reg_bus_arbiter;
  localparam int RD_LAT = 1;
  localparam int MAX_B  = 4;
  logic        sysclk = 1'b0;
  logic        reset_n;
  logic        h_req[2], h_wr[2], h_lock[2];
  logic [15:0] h_addr[2];
  logic [31:0] h_wdata[2];
  logic        fw_ack, eth_ack, reg_wen, owner, busy;
  logic [31:0] fw_rdata, eth_rdata, reg_wdata, reg_rdata;
  logic [15:0] reg_raddr, reg_waddr;
  bit   [31:0] rf_mem[256];
  bit          rf_vld[256];
  logic [31:0] exp_mem[256];
  logic [31:0] exp_rd[2];
  logic [15:0] last_addr;
  logic        m_owner, m_lock;
  int          m_streak;
  int          n_vec = 0, n_bad = 0;

  always #5 sysclk = ~sysclk;

  reg_bus_arbiter #(.RD_LATENCY(RD_LAT), .MAX_BURST(MAX_B)) dut (
    .sysclk(sysclk), .reset_n(reset_n),
    .fw_req(h_req[0]), .fw_wr(h_wr[0]), .fw_lock(h_lock[0]), .fw_addr(h_addr[0]), .fw_wdata(h_wdata[0]),
    .fw_ack(fw_ack), .fw_rdata(fw_rdata),
    .eth_req(h_req[1]), .eth_wr(h_wr[1]), .eth_lock(h_lock[1]), .eth_addr(h_addr[1]), .eth_wdata(h_wdata[1]),
    .eth_ack(eth_ack), .eth_rdata(eth_rdata),
    .reg_raddr(reg_raddr), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen),
    .reg_rdata(reg_rdata), .owner(owner), .busy(busy)
  );

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h04) ? 32'h12345678 : {24'hA5C300, a};
  endfunction

  // register file: one-cycle registered read, written on reg_wen
  always @(posedge sysclk) begin
    if (reg_wen) begin
      rf_mem[reg_waddr[7:0]] <= reg_wdata;
      rf_vld[reg_waddr[7:0]] <= 1'b1;
    end
    reg_rdata <= rf_vld[reg_raddr[7:0]] ? rf_mem[reg_raddr[7:0]] : init_val(reg_raddr[7:0]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic post(input int h, input logic wr, input logic lk, input logic [15:0] a, input logic [31:0] d);
    h_req[h] = 1'b1; h_wr[h] = wr; h_lock[h] = lk; h_addr[h] = a; h_wdata[h] = d;
  endtask

  task automatic model_reset();
    m_owner = 1'b1; m_lock = 1'b0; m_streak = 0;
    exp_rd[0] = '0; exp_rd[1] = '0; last_addr = '0;
  endtask

  // the incumbent keeps the bus on a tie only while it holds lock and has burst allowance left
  function automatic logic predict();
    if (h_req[0] && h_req[1]) begin
      if (m_lock && m_streak < MAX_B) return m_owner;
      return !m_owner;
    end
    return h_req[1];
  endfunction

  task automatic model_grant(input logic who);
    if (who == m_owner && m_lock) m_streak = (m_streak < MAX_B) ? m_streak + 1 : MAX_B;
    else m_streak = 0;
    m_owner = who;
  endtask

  task automatic model_done(input logic who);
    m_lock = h_lock[who];
    if (!m_lock) m_streak = 0;
  endtask

  task automatic run_txn(output logic who);
    logic wr;
    logic [15:0] a;
    logic [31:0] d, rd;
    check("idle_busy", busy, 0);
    check("idle_bus_hold", reg_waddr, last_addr);
    who = predict();
    wr = h_wr[who]; a = h_addr[who]; d = h_wdata[who]; rd = exp_mem[a[7:0]];
    model_grant(who);
    tick();
    check("acc_owner", owner, who);
    check("acc_raddr", reg_raddr, a);
    check("acc_waddr", reg_waddr, a);
    check("acc_wen", reg_wen, wr);
    check("acc_busy", busy, 1);
    if (wr) begin
      check("acc_wdata", reg_wdata, d);
      exp_mem[a[7:0]] = d;
    end else begin
      repeat (RD_LAT) begin
        tick();
        check("rwait_ack", {fw_ack, eth_ack}, 0);
        check("rwait_wen", reg_wen, 0);
      end
    end
    tick();
    check("grant_ack", who ? eth_ack : fw_ack, 1);
    check("other_ack", who ? fw_ack : eth_ack, 0);
    check("done_wen", reg_wen, 0);
    if (!wr) exp_rd[who] = rd;
    check("fw_rdata", fw_rdata, exp_rd[0]);
    check("eth_rdata", eth_rdata, exp_rd[1]);
    model_done(who);
    h_req[who] = 1'b0;
    last_addr = a;
    tick();
    check("post_ack", {fw_ack, eth_ack}, 0);
  endtask

  initial begin
    logic who, prev;
    logic [31:0] rd;
    reset_n = 1'b0;
    for (int h = 0; h < 2; h++) begin
      h_req[h] = 1'b0; h_wr[h] = 1'b0; h_lock[h] = 1'b0; h_addr[h] = '0; h_wdata[h] = '0;
    end
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(8'(i));
    model_reset();
    tick(); tick();
    check("rst_owner", owner, 1);
    check("rst_busy", busy, 0);
    check("rst_wen", reg_wen, 0);
    check("rst_ack", {fw_ack, eth_ack}, 0);
    check("rst_addr", {reg_raddr, reg_waddr}, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_fw_rdata", fw_rdata, 0);
    check("rst_eth_rdata", eth_rdata, 0);
    reset_n = 1'b1;

    post(0, 1'b1, 1'b0, 16'h0000, 32'h000C0000);
    run_txn(who);
    post(1, 1'b0, 1'b0, 16'h0004, 32'h0);
    run_txn(who);
    check("eth_read_value", eth_rdata, 32'h12345678);

    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int h = 0; h < 2; h++)
        if (!h_req[h]) post(h, 1'($urandom), 1'b0, 16'($urandom_range(0, 15)), $urandom);
      run_txn(who);
      if (i > 0) check("alternate", who, !prev);
      prev = who;
    end
    while (h_req[0] || h_req[1]) run_txn(who);

    for (int i = 0; i < 12; i++) begin
      if (!h_req[0]) post(0, 1'($urandom), 1'b0, 16'($urandom_range(0, 15)), $urandom);
      if (!h_req[1]) post(1, 1'($urandom), 1'b1, 16'($urandom_range(0, 15)), $urandom);
      run_txn(who);
    end
    h_lock[1] = 1'b0;
    while (h_req[0] || h_req[1]) run_txn(who);

    post(0, 1'b0, 1'b0, 16'h0004, 32'h0);
    tick(); tick();
    check("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_owner", owner, 1);
    check("arst_addr", {reg_raddr, reg_waddr}, 0);
    check("arst_wdata", reg_wdata, 0);
    check("arst_ack", {fw_ack, eth_ack}, 0);
    check("arst_fw_rdata", fw_rdata, 0);
    check("arst_eth_rdata", eth_rdata, 0);
    tick();
    check("arst_no_ack", {fw_ack, eth_ack}, 0);
    reset_n = 1'b1;
    model_reset();
    run_txn(who);
    check("rst_resume_fw", who, 0);

    post(0, 1'b0, 1'b0, 16'h0009, 32'h0);
    model_grant(1'b0);
    rd = exp_mem[9];
    tick();
    check("drop_acc_addr", reg_raddr, 16'h0009);
    h_req[0] = 1'b0;
    h_addr[0] = 16'hFFF6;
    repeat (RD_LAT) begin
      tick();
      check("drop_rwait_addr", reg_raddr, 16'h0009);
      check("drop_rwait_ack", fw_ack, 0);
    end
    tick();
    check("drop_ack", fw_ack, 1);
    check("drop_rdata", fw_rdata, rd);
    exp_rd[0] = rd;
    model_done(1'b0);
    last_addr = 16'h0009;
    tick();
    check("drop_ack_once", fw_ack, 0);
    post(1, 1'b1, 1'b0, 16'h0007, 32'hCAFE0007);
    run_txn(who);
    check("drop_next_grant", who, 1);

    for (int i = 0; i < 250; i++) begin
      for (int h = 0; h < 2; h++)
        if (!h_req[h] && $urandom_range(0, 3) != 0)
          post(h, 1'($urandom), 1'($urandom), 16'($urandom_range(0, 15)), $urandom);
      if (h_req[0] || h_req[1]) run_txn(who);
      else begin
        check("quiet", {busy, fw_ack, eth_ack}, 0);
        tick();
        check("quiet_owner", owner, m_owner);
      end
    end
    while (h_req[0] || h_req[1]) run_txn(who);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
